disp_mux_bcd: RTL and testbench

Time-multiplexed 4-digit seven-segment driver consuming the stopwatch BCD outputs d3..d0. It refreshes one digit at a time and latches the inputs once per refresh frame, so a digit never tears mid-frame. It also provides leading-zero blanking, per-digit decimal points and an invalid-code indication. It sits directly downstream of the stopwatch, between its digit outputs and the board's anode and segment pins.

---
 rtl/disp_mux_bcd.sv | 95 +++++++++
 tb/tb_disp_mux_bcd.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/disp_mux_bcd.sv
// Time-multiplexed 4-digit seven-segment driver with per-frame input shadowing,
// leading-zero blanking and decimal points. Optional duty-cycle dimming: DISP_DIMMING_EN.
module disp_mux_bcd #(
   parameter int N = 18
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] d3,
   input  logic [3:0] d2,
   input  logic [3:0] d1,
   input  logic [3:0] d0,
   input  logic [3:0] dp_in,
   input  logic       blank_lz,
`ifdef DISP_DIMMING_EN
   input  logic [1:0] duty,
`endif
   output logic [3:0] an,
   output logic [7:0] sseg
);

   logic [N-1:0]      q;
   logic [3:0][3:0]   s_dig;
   logic [3:0]        s_dp;
   logic [1:0]        sel;
   logic [3:0]        an_nx;
   logic [7:0]        sseg_nx;
   logic              b3, b2, b1;
   logic              blanked;
   logic              lit;

   assign sel = q[N-1:N-2];

   // Active-low {g,f,e,d,c,b,a}; codes above 9 show a dash.
   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = 7'b0111111;
      endcase
   endfunction

   // Blanking chain works on the shadowed digits so it is stable for a whole frame.
   assign b3 = blank_lz & (s_dig[3] == 4'd0);
   assign b2 = b3 & (s_dig[2] == 4'd0);
   assign b1 = b2 & (s_dig[1] == 4'd0);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      an_nx   = 4'b1111;
      sseg_nx = 8'hFF;
      case (sel)
         2'd3:    blanked = b3;
         2'd2:    blanked = b2;
         2'd1:    blanked = b1;
         default: blanked = 1'b0;
      endcase
`ifdef DISP_DIMMING_EN
      lit = (q[N-3:N-4] <= duty);
`else
      lit = 1'b1;
`endif
      if (!blanked && lit) begin
         an_nx   = ~(4'b0001 << sel);
         sseg_nx = {~s_dp[sel], seg7(s_dig[sel])};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q     <= '0;
         s_dig <= '0;
         s_dp  <= '0;
         an    <= 4'b1111;
         sseg  <= 8'hFF;
      end else begin
         // NOTE: non-blocking so the shadow load and decode both see this cycle's q.
         q    <= q + 1'b1;
         an   <= an_nx;
         sseg <= sseg_nx;
         if (q == '1) begin
            s_dig <= {d3, d2, d1, d0};
            s_dp  <= dp_in;
         end
      end
   end

endmodule

// File: tb/tb_disp_mux_bcd.sv
// Self-checking bench for disp_mux_bcd (N=4): directed scenarios plus a randomized
// run, all compared against a frame-level behavioural model.
module tb_disp_mux_bcd;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] d3 = '0, d2 = '0, d1 = '0, d0 = '0;
   logic [3:0] dp_in = '0;
   logic       blank_lz = 1'b0;
   logic [3:0] an;
   logic [7:0] sseg;

   int checks = 0;
   int errors = 0;

   // Behavioural model: cycle position within a 16-cycle frame and the latched frame data.
   int         m_cnt = 0;
   int         m_sh [4] = '{0, 0, 0, 0};
   logic [3:0] m_dp = '0;
   logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};

   disp_mux_bcd #(.N(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .d3       (d3),
      .d2       (d2),
      .d1       (d1),
      .d0       (d0),
      .dp_in    (dp_in),
      .blank_lz (blank_lz),
      .an       (an),
      .sseg     (sseg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // One clock: predict from pre-edge model state, advance the model, then compare.
   task automatic step(input string tag);
      int         sel;
      int         lz;
      logic [3:0] e_an;
      logic [7:0] e_sseg;
      e_an   = 4'b1111;
      e_sseg = 8'hFF;
      if (rst) begin
         m_cnt = 0;
         m_sh  = '{0, 0, 0, 0};
         m_dp  = '0;
      end else begin
         sel = m_cnt / 4;
         lz  = 0;
         if (blank_lz)
            for (int i = 3; i >= 1; i--)
               if (m_sh[i] == 0 && lz == 3 - i) lz++;
         if (sel < 4 - lz) begin
            e_an[sel] = 1'b0;
            e_sseg    = seg_tab[m_sh[sel]];
            if (m_dp[sel]) e_sseg[7] = 1'b0;
         end
         if (m_cnt == 15) begin
            m_sh[3] = int'(d3);
            m_sh[2] = int'(d2);
            m_sh[1] = int'(d1);
            m_sh[0] = int'(d0);
            m_dp    = dp_in;
         end
         m_cnt = (m_cnt + 1) % 16;
      end
      @(posedge clk);
      #1;
      check({tag, "_an"}, {4'h0, an}, {4'h0, e_an});
      check({tag, "_sseg"}, sseg, e_sseg);
      check({tag, "_one_anode"}, 8'($countones(~an) <= 1), 8'd1);
   endtask

   task automatic run_to(input int target, input string tag);
      for (int i = 0; i < 17 && m_cnt != target; i++) step(tag);
   endtask

   // First cycle of slot k: the step whose pre-edge count was 4k.
   task automatic check_slot(input int k, input logic [3:0] e_an, input logic [7:0] e_sseg,
                             input string tag);
      run_to(4 * k + 1, tag);
      check({tag, "_const_an"}, {4'h0, an}, {4'h0, e_an});
      check({tag, "_const_sseg"}, sseg, e_sseg);
   endtask

   initial begin
      // 1. Reset
      step("reset");
      check("reset_an", {4'h0, an}, 8'h0F);
      check("reset_sseg", sseg, 8'hFF);
      check("reset_q", 8'(dut.q), 8'd0);
      rst = 1'b0;
      step("count0");
      check("q_after1", 8'(dut.q), 8'd1);
      step("count1");
      check("q_after2", 8'(dut.q), 8'd2);

      // 2. Plain digits 4,3,2,1
      {d3, d2, d1, d0} = {4'd4, 4'd3, 4'd2, 4'd1};
      run_to(0, "load4321");
      check_slot(0, 4'b1110, 8'hF9, "d4321_s0");
      step("d4321_s0b");
      step("d4321_s0c");
      step("d4321_s0d");
      check("d4321_latency", sseg, 8'hF9);
      check_slot(1, 4'b1101, 8'hA4, "d4321_s1");
      check_slot(2, 4'b1011, 8'hB0, "d4321_s2");
      check_slot(3, 4'b0111, 8'h99, "d4321_s3");

      // 3. Leading-zero blanking 0,0,0,5 then all zero
      blank_lz = 1'b1;
      {d3, d2, d1, d0} = {4'd0, 4'd0, 4'd0, 4'd5};
      run_to(0, "load0005");
      check_slot(0, 4'b1110, 8'h92, "lz5_s0");
      check_slot(1, 4'b1111, 8'hFF, "lz5_s1");
      check_slot(2, 4'b1111, 8'hFF, "lz5_s2");
      check_slot(3, 4'b1111, 8'hFF, "lz5_s3");
      d0 = 4'd0;
      run_to(0, "load0000");
      check_slot(0, 4'b1110, 8'hC0, "lz0_s0");
      check_slot(1, 4'b1111, 8'hFF, "lz0_s1");

      // 4. Inner zeros kept: 0,7,0,0
      {d3, d2, d1, d0} = {4'd0, 4'd7, 4'd0, 4'd0};
      run_to(0, "load0700");
      check_slot(0, 4'b1110, 8'hC0, "in_s0");
      check_slot(1, 4'b1101, 8'hC0, "in_s1");
      check_slot(2, 4'b1011, 8'hF8, "in_s2");
      check_slot(3, 4'b1111, 8'hFF, "in_s3");

      // 5. Mid-frame change invisible until wrap; dp and invalid code
      blank_lz = 1'b0;
      {d3, d2, d1, d0} = {4'd0, 4'd0, 4'd2, 4'd0};
      run_to(0, "load0020");
      run_to(2, "mid");
      d1    = 4'd8;
      d2    = 4'hA;
      dp_in = 4'b0010;
      check_slot(1, 4'b1101, 8'hA4, "hold_s1");
      check_slot(2, 4'b1011, 8'hC0, "hold_s2");
      run_to(0, "load_new");
      check_slot(0, 4'b1110, 8'hC0, "new_s0");
      check_slot(1, 4'b1101, 8'h00, "new_s1_dp");
      check_slot(2, 4'b1011, 8'hBF, "new_s2_dash");
      check_slot(3, 4'b0111, 8'hC0, "new_s3");
      dp_in = 4'b0000;

      // 6. Reset mid-slot sel=2
      {d3, d2, d1, d0} = {4'd9, 4'd9, 4'd9, 4'd9};
      blank_lz = 1'b1;
      run_to(10, "to_sel2");
      rst = 1'b1;
      step("midrst");
      check("midrst_an", {4'h0, an}, 8'h0F);
      check("midrst_q", 8'(dut.q), 8'd0);
      rst = 1'b0;
      step("postrst0");
      check("postrst_an", {4'h0, an}, 8'h0E);
      check("postrst_sseg", sseg, 8'hC0);
      check_slot(1, 4'b1111, 8'hFF, "postrst_s1");
      run_to(0, "load9999");
      check_slot(3, 4'b0111, 8'h90, "reload_s3");

      // Randomized run against the model
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            d3 = 4'($urandom_range(0, 15) < 8 ? 0 : $urandom_range(0, 15));
            d2 = 4'($urandom_range(0, 15) < 6 ? 0 : $urandom_range(0, 15));
            d1 = 4'($urandom_range(0, 15) < 4 ? 0 : $urandom_range(0, 15));
            d0 = 4'($urandom_range(0, 15));
            dp_in = 4'($urandom_range(0, 15));
         end
         if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
         rst = ($urandom_range(0, 63) == 0);
         step("rand");
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
